// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the program-counter / fetch sequencer.
package pc_fetch_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int              TIMEOUT_CYC_DEFAULT = 16;

  // Sequencer states; TRAP is only reachable when misaligned-target trapping is built in.
  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    RETRY,
    ISSUE,
    TRAP
  } state_t;

  // The timeout counter needs one spare bit so TIMEOUT_CYC-1 always fits.
  function automatic int cnt_width(input int timeout_cyc);
    return $clog2(timeout_cyc) + 1;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: async active-low reset to a fixed value, load enable.
module pc_reg
  import pc_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VAL = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] d,
  output logic [PC_W-1:0] q
);

  // Hold the PC; update only when the sequencer retires an instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is written with <= so every flop samples pre-edge values, independent of block order.
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch sequencer of the single-cycle CPU.
// Fetches at pc_o over a req/ack handshake, holds the instruction until the
// core accepts it, then advances the PC (jump > branch > pc_plus4_i).
// Optional build macro: PC_MISALIGN_TRAP_EN -- a misaligned next PC parks the
// sequencer in TRAP instead of being silently word-aligned.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int              TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [PC_W-1:0]    pc_o,
  input  logic [PC_W-1:0]    pc_plus4_i,
  input  logic               branch_i,
  input  logic [PC_W-1:0]    branch_target_i,
  input  logic               jump_i,
  input  logic [PC_W-1:0]    jump_target_i,
  input  logic               stall_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic               retry_o,
  output logic               trap_o
);

  localparam int              CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pc_load;
  logic                instr_load;
  logic [PC_W-1:0]     next_pc;
  logic [PC_W-1:0]     pc_d;

  // Next-PC select: jump has priority over branch, otherwise sequential.
  always_comb begin
    next_pc = pc_plus4_i;
    if (jump_i) begin
      next_pc = jump_target_i;
    end else if (branch_i) begin
      next_pc = branch_target_i;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Keep the raw target so a trap leaves the faulting address visible on pc_o.
  logic misaligned;
  assign pc_d       = next_pc;
  assign misaligned = |next_pc[1:0];
`else
  // Without trapping, targets are forced onto a word boundary.
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
  assign pc_d = next_pc & ALIGN_MASK;
`endif

  pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk_i),
    .rst_n (rst_i),
    .load  (pc_load),
    .d     (pc_d),
    .q     (pc_o)
  );

  // State register and fetch-timeout counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Instruction holding register, loaded on the fetch ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_o <= '0;
    end else if (instr_load) begin
      instr_o <= imem_data_i;
    end
  end

  // Next-state logic, timeout counting and PC/instruction load strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_load    = 1'b0;
    instr_load = 1'b0;

    case (state_q)
      BOOT: begin
        cnt_d   = '0;
        state_d = FETCH;
      end

      FETCH: begin
        if (imem_ack_i) begin
          instr_load = 1'b1;
          cnt_d      = '0;
          state_d    = ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RETRY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Request dropped for one cycle; any ack seen here is stale and ignored.
      RETRY: begin
        cnt_d   = '0;
        state_d = FETCH;
      end

      ISSUE: begin
        if (!stall_i) begin
          pc_load = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
          state_d = misaligned ? TRAP : FETCH;
`else
          state_d = FETCH;
`endif
        end
      end

`ifdef PC_MISALIGN_TRAP_EN
      // Terminal until reset.
      TRAP: begin
        state_d = TRAP;
      end
`endif

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign imem_req_o    = (state_q == FETCH);
  assign imem_addr_o   = pc_o;
  assign instr_valid_o = (state_q == ISSUE);
  assign retry_o       = (state_q == RETRY);
`ifdef PC_MISALIGN_TRAP_EN
  assign trap_o        = (state_q == TRAP);
`else
  assign trap_o        = 1'b0;
`endif

endmodule
